instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction sequencer directly upstream of the ISA datapath (register file + ALU + RAM).
- Holds a small program memory loaded through a write port, and steps a program counter.
- Presents one 21-bit instruction word at a time on `instruccion`, with a valid/ready handshake.
- Drives an all-zero (no-write, no-op) word whenever no instruction is being issued, because the downstream datapath is combinational and acts on whatever word it sees.

Parameters:
- AW, 5, program-memory address width.
- DEPTH, 32, number of program words; must equal 2**AW.
- IW, 21, instruction width. Field map: [20] halt, [19:15] DL1, [14:10] DL2, [9] BR WE, [8:6] AluOp, [5:1] RAM Dir, [0] RAM WE.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin (or restart) execution from address 0; sampled only in IDLE or HALT.
- load_we  in  1  program-memory write enable.
- load_dir  in  AW  program-memory write address.
- load_dato  in  IW  program-memory write data.
- instr_ready  in  1  downstream accepts the current word this cycle.
- instruccion  out  IW  instruction word to the datapath; zero when instr_valid=0.
- instr_valid  out  1  instruccion holds a live instruction.
- pc  out  AW  address of the word currently fetched or issued.
- busy  out  1  high in FETCH or ISSUE.
- done  out  1  high in HALT.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; pc=0; instruccion=0; instr_valid=0; busy=0; done=0.
  - Program memory is NOT cleared.
  - Reset wins over every other input, including mid-FETCH and mid-ISSUE.
  - An in-flight word is dropped, and instruccion is 0 from the next cycle.
- Program memory:
  - DEPTH x IW array, synchronous write, registered read.
  - Write occurs when load_we=1 and busy=0.
  - load_we while busy=1 is ignored; memory is unchanged.
- States:
  - IDLE:
    - outputs zero.
    - start=1 -> pc<=0, go to FETCH.
  - FETCH (one cycle):
    - memory read at pc; the word is registered at the end of the cycle.
    - If word[20]=1 -> go to HALT; instr_valid stays 0; the halt word is never presented.
    - Otherwise -> instruccion<=word, instr_valid<=1, go to ISSUE.
  - ISSUE:
    - instr_valid=1, and instruccion is held stable until the handshake.
    - On instr_valid & instr_ready:
      - instruccion<=0 and instr_valid<=0 next cycle.
      - If pc==DEPTH-1 -> go to HALT (no wrap).
      - Else pc<=pc+1, go to FETCH.
    - instr_ready=0 -> remain in ISSUE, everything held.
  - HALT:
    - done=1; pc holds the halting address.
    - start=1 -> pc<=0, done<=0, go to FETCH.
    - load writes are permitted.
- Latency and throughput:
  - start sampled at edge N -> FETCH during N+1 -> instr_valid=1 during N+2.
  - Each accepted word costs 2 cycles (ISSUE + FETCH), so at most 1 instruction per 2 cycles.
  - instr_valid never goes high in two consecutive cycles.
- Outputs:
  - All outputs are registered.
  - instr_ready is ignored when instr_valid=0.
  - start is ignored in FETCH and ISSUE.
- Simultaneous events:
  - load_we and start in the same IDLE/HALT cycle: the write lands, and the FETCH in the next cycle reads the newly written value.

Test Plan:
- Load [0]=0x00A4C5, [1]=0x0214C3, [2]=0x100000; start; hold instr_ready=1:
  - instr_valid is high at cycles 2 and 4 after start, with instruccion=0x00A4C5 then 0x0214C3.
  - instruccion=0 in all other cycles.
  - done=1 from cycle 6, pc=2.
- Same program, instr_ready=0 for 5 cycles during the first ISSUE:
  - instruccion holds 0x00A4C5 and pc=0 throughout.
  - Word 1 issues 2 cycles after instr_ready rises.
- [0]=0x1FFFFF; start:
  - instr_valid never asserts; done=1 two cycles after start; the datapath sees instruccion=0 throughout.
- Fill all 32 words without bit 20 set; start; ready=1:
  - 32 valid pulses, pc steps 0..31.
  - After the accept at pc=31, state goes to HALT with pc=31 (no wrap to 0).
- Run the program, then pulse load_we with load_dir=1, load_dato=0x000001 during ISSUE:
  - Write is ignored, and re-running after done issues the original word 1.
  - After done, the same write succeeds and restart issues 0x000001 as word 1.
- Drive rst_n=0 for one cycle while in ISSUE with ready=0:
  - Next cycle: instr_valid=0, instruccion=0, pc=0, state IDLE.
  - Memory is intact; start replays from word 0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction sequencer in front of the ISA datapath.
// Holds a DEPTH x IW program memory loaded through a write port, steps a
// program counter and offers one instruction word at a time downstream.
// Because the datapath is combinational, instruccion is forced to zero
// (a no-write no-op) in every cycle where no instruction is offered.
//
// Handshake: instr_valid/instr_ready follow strict valid/ready rules. Once
// instr_valid rises, instruccion and pc stay frozen until a cycle in which
// instr_ready is also high; that cycle is the transfer. instr_valid never
// depends combinationally on instr_ready, and instr_ready is a don't-care
// while instr_valid is low.
module instr_fetch #(
    parameter int AW    = 5,
    parameter int DEPTH = 32,
    parameter int IW    = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          load_we,
    input  logic [AW-1:0] load_dir,
    input  logic [IW-1:0] load_dato,
    input  logic          instr_ready,
    output logic [IW-1:0] instruccion,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    // Sequencer states; state_dbg mirrors the current one for observation.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // Top bit of every word marks the end of the program.
    localparam int HALT_BIT = IW - 1;

    // Last valid address; execution stops here instead of wrapping.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [IW-1:0] mem [DEPTH];

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [AW-1:0] pc_nx;
    logic [IW-1:0] instr_nx;
    logic          valid_nx;
    logic [IW-1:0] fetch_word;
    logic          accept;

    // The read is only consumed in FETCH, where it lands in the output
    // register at the end of the cycle, so the memory read is registered.
    assign fetch_word = mem[pc];
    assign accept     = instr_valid & instr_ready;
    assign state_dbg  = state;

    // Program load port: only while the sequencer is stopped, so a running
    // program can never be altered underneath itself. Not cleared by reset.
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            mem[load_dir] <= load_dato;
        end
    end

    // Next-state and next-output decision for the sequencer.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instruccion;
        valid_nx = instr_valid;
        case (state)
            S_IDLE: begin
                instr_nx = '0;
                valid_nx = 1'b0;
                if (start) begin
                    pc_nx    = '0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_word[HALT_BIT]) begin
                    // The halt word itself is never presented downstream.
                    instr_nx = '0;
                    valid_nx = 1'b0;
                    state_nx = S_HALT;
                end else begin
                    instr_nx = fetch_word;
                    valid_nx = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    instr_nx = '0;
                    valid_nx = 1'b0;
                    if (pc == LAST_ADDR) begin
                        state_nx = S_HALT;
                    end else begin
                        pc_nx    = pc + AW'(1);
                        state_nx = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                instr_nx = '0;
                valid_nx = 1'b0;
                if (start) begin
                    pc_nx    = '0;
                    state_nx = S_FETCH;
                end
            end
            default: begin
                state_nx = S_IDLE;
                pc_nx    = '0;
                instr_nx = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruccion <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instruccion <= instr_nx;
            instr_valid <= valid_nx;
            busy        <= (state_nx == S_FETCH) || (state_nx == S_ISSUE);
            done        <= (state_nx == S_HALT);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch. The reference model walks
// the bench's copy of program memory to predict the issued words and the
// halting address; a monitor process checks every output cycle against it.
module tb_instr_fetch;

    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int IW    = 21;
    localparam int QW    = AW + IW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          load_we;
    logic [AW-1:0] load_dir;
    logic [IW-1:0] load_dato;
    logic          instr_ready;
    logic [IW-1:0] instruccion;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    logic [IW-1:0] model_mem [DEPTH];
    logic [QW-1:0] exp_q[$];

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;
    bit prev_accept = 0;
    int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random

    instr_fetch #(.AW(AW), .DEPTH(DEPTH), .IW(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .load_we     (load_we),
        .load_dir    (load_dir),
        .load_dato   (load_dato),
        .instr_ready (instr_ready),
        .instruccion (instruccion),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // Clock and reset-time defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready driver, updated just after each rising edge.
    initial begin
        instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       instr_ready = 1'b0;
                1:       instr_ready = 1'b1;
                default: instr_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every live word must match the scoreboard head (address and
    // data); idle cycles must show a zero word; no back-to-back issues.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (instr_valid) begin
                check("issue_gap", 32'(prev_accept), 32'h0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_issue: got pc=%0d word=0x%0h, expected none", pc, instruccion);
                end else begin
                    check("issue_word", 32'({pc, instruccion}), 32'(exp_q[0]));
                    if (instr_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_zero", 32'(instruccion), 32'h0);
            end
            prev_accept = instr_valid && instr_ready;
        end else begin
            prev_accept = 0;
        end
    end

    // Reference model: the program runs from address 0 until a halt word or
    // the last address; every non-halt word on the way is issued in order.
    task automatic push_expect(output int exp_pc);
        exp_q.delete();
        exp_pc = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            if (model_mem[a][IW-1]) begin
                exp_pc = a;
                break;
            end
            exp_q.push_back({AW'(a), model_mem[a]});
        end
    endtask

    // Driver: one program word while the sequencer is stopped.
    task automatic load_word(input int dir, input logic [IW-1:0] dato);
        load_we   = 1'b1;
        load_dir  = AW'(dir);
        load_dato = dato;
        @(posedge clk);
        #1;
        load_we = 1'b0;
        model_mem[dir] = dato;
    endtask

    task automatic load_basic();
        for (int a = 0; a < DEPTH; a++) begin
            logic [IW-1:0] w;
            case (a)
                0:       w = 21'h00A4C5;
                1:       w = 21'h0214C3;
                2:       w = 21'h100000;
                default: w = '0;
            endcase
            load_word(a, w);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", 32'(instr_valid), 32'h1);
    endtask

    task automatic wait_done(input int exp_pc);
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done), 32'h1);
        check("halt_pc", 32'(pc), 32'(exp_pc));
        check("halt_busy", 32'(busy), 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ep;
        rst_n     = 1'b0;
        start     = 1'b0;
        load_we   = 1'b0;
        load_dir  = '0;
        load_dato = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_word", 32'(instruccion), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1;

        // Basic program, ready held high: cycle-exact timing.
        load_basic();
        ready_mode = 1;
        @(posedge clk);
        #1;
        push_expect(ep);
        start_pulse();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("t1_valid", 32'(instr_valid), 32'((k == 2) || (k == 4)));
            check("t1_done", 32'(done), 32'(k >= 6));
            if (k == 2) check("t1_word0", 32'(instruccion), 32'h00A4C5);
            if (k == 4) check("t1_word1", 32'(instruccion), 32'h0214C3);
        end
        wait_done(ep);

        // Stall the first issue for five cycles.
        ready_mode = 0;
        @(posedge clk);
        #1;
        push_expect(ep);
        start_pulse();
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_word", 32'(instruccion), 32'h00A4C5);
            check("stall_pc", 32'(pc), 32'h0);
            @(negedge clk);
        end
        ready_mode = 1;
        begin
            int n = 0;
            while (!instr_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        check("stall_gap", 32'(instr_valid), 32'h0);
        @(negedge clk);
        check("stall_w1_valid", 32'(instr_valid), 32'h1);
        check("stall_w1_word", 32'(instruccion), 32'h0214C3);
        wait_done(ep);

        // Halt word at address 0.
        load_word(0, 21'h1FFFFF);
        push_expect(ep);
        start_pulse();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("h0_valid", 32'(instr_valid), 32'h0);
            check("h0_word", 32'(instruccion), 32'h0);
            check("h0_done", 32'(done), 32'(k >= 2));
        end
        wait_done(ep);

        // Full memory without halt words, random ready: no wrap past the end.
        for (int a = 0; a < DEPTH; a++) load_word(a, IW'($urandom) & 21'h0FFFFF);
        ready_mode = 2;
        push_expect(ep);
        start_pulse();
        wait_done(ep);

        // Write while busy is ignored; the same write after done lands.
        load_basic();
        ready_mode = 0;
        @(posedge clk);
        #1;
        push_expect(ep);
        start_pulse();
        wait_valid();
        load_we   = 1'b1;
        load_dir  = AW'(1);
        load_dato = 21'h000001;
        @(posedge clk);
        #1;
        load_we = 1'b0;
        ready_mode = 1;
        wait_done(ep);
        push_expect(ep);
        start_pulse();
        wait_done(ep);
        load_word(1, 21'h000001);
        push_expect(ep);
        start_pulse();
        wait_done(ep);

        // Load and start in the same cycle: the fetch sees the new word.
        begin
            logic [IW-1:0] w;
            w = IW'($urandom) & 21'h0FFFFF;
            load_we   = 1'b1;
            load_dir  = '0;
            load_dato = w;
            start     = 1'b1;
            model_mem[0] = w;
            push_expect(ep);
            @(posedge clk);
            #1;
            load_we = 1'b0;
            start   = 1'b0;
            wait_done(ep);
        end

        // Reset in the middle of a stalled issue.
        ready_mode = 0;
        @(posedge clk);
        #1;
        push_expect(ep);
        start_pulse();
        wait_valid();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mr_valid", 32'(instr_valid), 32'h0);
        check("mr_word", 32'(instruccion), 32'h0);
        check("mr_pc", 32'(pc), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_done", 32'(done), 32'h0);
        check("mr_state", 32'(state_dbg), 32'h0);
        ready_mode = 1;
        @(posedge clk);
        #1;
        push_expect(ep);
        start_pulse();
        wait_done(ep);

        // Random programs with random halt positions and random ready.
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [IW-1:0] w;
                w = IW'($urandom) & 21'h0FFFFF;
                if ($urandom_range(0, 11) == 0) w[IW-1] = 1'b1;
                load_word(a, w);
            end
            push_expect(ep);
            start_pulse();
            wait_done(ep);
        end

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
